// File: rtl/color_pkg.sv
// Shared types and helpers for the palette colour mapper.
// Colour modes, the black constant and the palette reset ramp.
package color_pkg;

    typedef enum logic [1:0] {
        MODE_GRAY   = 2'd0,
        MODE_PAL_LO = 2'd1,
        MODE_PAL_HI = 2'd2,
        MODE_RSVD   = 2'd3
    } color_mode_t;

    // Wide enough for any channel width in use; callers slice to 3*CH_W.
    localparam logic [95:0] RGB_BLACK = '0;

    function automatic logic [31:0] ramp_chan(
        input int unsigned idx,
        input int unsigned ch_w,
        input int unsigned depth
    );
        return 32'(idx << (ch_w - $clog2(depth)));
    endfunction

endpackage

// File: rtl/color_palette_ram.sv
// Register-file palette: one write port, one combinational read port.
// Reset loads a grayscale ramp across all entries.
module color_palette_ram
    import color_pkg::*;
#(
    parameter  int CH_W      = 8,
    parameter  int PAL_DEPTH = 16,
    localparam int AW        = $clog2(PAL_DEPTH),
    localparam int RGB_W     = 3 * CH_W
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [RGB_W-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [RGB_W-1:0] o_rdata
);

    logic [RGB_W-1:0] r_mem [PAL_DEPTH];

    always_ff @(posedge clk) begin
        if (!nrst) begin
            for (int i = 0; i < PAL_DEPTH; i++) begin
                r_mem[i] <= {3{CH_W'(ramp_chan(i, CH_W, PAL_DEPTH))}};
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/palette_color_mapper.sv
// Two-stage iteration-count to RGB colouriser with valid/ready on both sides.
// S1 holds pixel, mode and palette index; S2 holds the final colour.
module palette_color_mapper
    import color_pkg::*;
#(
    parameter  int ITER_W    = 8,
    parameter  int CH_W      = 8,
    parameter  int PAL_DEPTH = 16,
    localparam int AW        = $clog2(PAL_DEPTH),
    localparam int RGB_W     = 3 * CH_W
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [1:0]        mode,
    input  logic              pal_we,
    input  logic [AW-1:0]     pal_waddr,
    input  logic [RGB_W-1:0]  pal_wdata,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ITER_W-1:0] iteration,
    input  logic              ismandelbrot,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [RGB_W-1:0]  rgb
);

    logic              r_s1_valid;
    logic              r_s1_black;
    logic [ITER_W-1:0] r_s1_iter;
    color_mode_t       r_s1_mode;
    logic [AW-1:0]     r_s1_idx;
    logic              r_s2_valid;
    logic [RGB_W-1:0]  r_s2_rgb;

    logic              w_adv;
    logic              w_s1_load;
    color_mode_t       w_mode;
    logic [AW-1:0]     w_idx;
    logic [CH_W-1:0]   w_gray;
    logic [RGB_W-1:0]  w_pal;
    logic [RGB_W-1:0]  w_rgb;

    assign w_mode    = color_mode_t'(mode);
    assign w_adv     = ~r_s2_valid | out_ready;
    assign w_s1_load = w_adv | ~r_s1_valid;
    assign in_ready  = nrst & w_s1_load;

    always_comb begin
        w_idx = iteration[AW-1:0];
        if (w_mode == MODE_PAL_HI) begin
            w_idx = iteration[ITER_W-1 -: AW];
        end
    end

    // Left-justify the count into one channel.
    if (ITER_W >= CH_W) begin : g_gray_trunc
        assign w_gray = r_s1_iter[ITER_W-1 -: CH_W];
    end else begin : g_gray_pad
        assign w_gray = {r_s1_iter, {(CH_W - ITER_W){1'b0}}};
    end

    always_comb begin
        case (r_s1_mode)
            MODE_PAL_LO, MODE_PAL_HI: w_rgb = w_pal;
            default:                  w_rgb = {3{w_gray}};
        endcase
        if (r_s1_black) begin
            w_rgb = RGB_BLACK[RGB_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_s1_valid <= 1'b0;
            r_s1_black <= 1'b0;
            r_s1_iter  <= '0;
            r_s1_mode  <= MODE_GRAY;
            r_s1_idx   <= '0;
        end else if (w_s1_load) begin
            r_s1_valid <= in_valid;
            r_s1_black <= ismandelbrot;
            r_s1_iter  <= iteration;
            r_s1_mode  <= w_mode;
            r_s1_idx   <= w_idx;
        end
    end

    // Palette is read on the transfer edge, so a same-edge write is not seen.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_s2_valid <= 1'b0;
            r_s2_rgb   <= '0;
        end else if (w_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_rgb <= w_rgb;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign rgb       = r_s2_rgb;

    color_palette_ram #(
        .CH_W      (CH_W),
        .PAL_DEPTH (PAL_DEPTH)
    ) u_pal (
        .clk     (clk),
        .nrst    (nrst),
        .i_we    (pal_we),
        .i_waddr (pal_waddr),
        .i_wdata (pal_wdata),
        .i_raddr (r_s1_idx),
        .o_rdata (w_pal)
    );

endmodule

// File: doc/palette_color_mapper.md
# palette_color_mapper

Parametrised, pipelined successor to the fractal colouriser: maps per-pixel escape-iteration counts to packed RGB via grayscale or a runtime-programmable palette, with in-set pixels forced black. Sits between the Mandelbrot iteration engine and the pixel/frame-buffer writer. Uses valid/ready handshakes on both sides and sustains one pixel per cycle with two-cycle latency.

## Interface
- ITER_W, 8, iteration count width
- CH_W, 8, bits per colour channel; RGB is 3*CH_W wide
- PAL_DEPTH, 16, palette entries; power of two, 2..2^ITER_W, log2(PAL_DEPTH) <= CH_W
- clk  in  1  system clock, all state on rising edge
- nrst  in  1  synchronous active-low reset
- mode  in  2  colour mode, sampled with each accepted pixel
- pal_we  in  1  palette write strobe
- pal_waddr  in  log2(PAL_DEPTH)  palette write index
- pal_wdata  in  3*CH_W  palette entry, {R,G,B}
- in_valid  in  1  pixel present on iteration/ismandelbrot
- in_ready  out  1  block accepts pixel this cycle
- iteration  in  ITER_W  escape iteration count
- ismandelbrot  in  1  pixel is inside the set
- out_valid  out  1  rgb holds a valid pixel
- out_ready  in  1  downstream accepts pixel
- rgb  out  3*CH_W  {R,G,B}, R in MSBs

## Operation
- Modes: 0 GRAY: every channel = iteration left-justified into CH_W (MSBs kept if ITER_W > CH_W, zero-filled LSBs if ITER_W < CH_W). 1 PAL_LO: rgb = pal[iteration mod PAL_DEPTH]. 2 PAL_HI: rgb = pal[iteration >> (ITER_W - log2(PAL_DEPTH))]. 3 reserved: behaves as GRAY.
- ismandelbrot = 1 forces rgb = 0 in every mode.
- Palette: PAL_DEPTH x 3*CH_W registers. Reset contents: entry i, every channel = i << (CH_W - log2(PAL_DEPTH)) (grayscale ramp).
- Write: on rising edge with pal_we = 1, pal[pal_waddr] <= pal_wdata. Writes are independent of pixel flow and never stall it.
- Pipeline: stage S1 registers pixel, mode and computed palette index; stage S2 registers final rgb (palette read plus black/gray select). A pixel moves S1->S2 when adv = ~out_valid | out_ready.
- in_ready = nrst & (adv | ~s1_valid). A pixel is accepted on an edge with in_valid & in_ready.
- out_valid = s2_valid. rgb and out_valid stay stable while out_valid & ~out_ready.

## Timing
- Reset (nrst low at an edge): s1_valid = 0, out_valid = 0, rgb = 0, palette = ramp. in_ready = 0 while nrst is low and 1 on the first cycle after release.
- Reset mid-operation discards in-flight pixels; no partial output appears.
- Latency: a pixel accepted at edge k is presented on rgb/out_valid after edge k+1.
- Throughput: 1 pixel/cycle with out_ready held high.
- Backpressure: with out_ready low and both stages full, in_ready = 0. No pixel is dropped or duplicated. Flow resumes on the edge where out_ready = 1.
- Palette read happens at the S1->S2 transfer edge. A write to the same entry on that edge is not seen (read-before-write); lookups on later edges see the new value.
- A write to an entry while a stalled pixel holds S2 does not alter that pixel's rgb.
- Mode changes affect only pixels accepted on or after the edge where the new value is sampled.

## Structure
- Package color_pkg:
  - color_mode_t enum: MODE_GRAY = 0, MODE_PAL_LO = 1, MODE_PAL_HI = 2, MODE_RSVD = 3.
  - Constant RGB_BLACK.
  - Ramp-init function, parametrised by CH_W and depth.
- One sub-module, color_palette_ram:
  - Register-file palette with synchronous-reset ramp.
  - One write port, one combinational read port.
- Top level holds the two pipeline stages, the index and gray computation, and the handshake logic.

## Test plan
- Reset then GRAY, defaults, out_ready = 1, stream iteration 0, 1, 0x80, 0xFF -> rgb 0x000000, 0x010101, 0x808080, 0xFFFFFF on consecutive cycles, first one two edges after acceptance.
- PAL_LO with reset palette, iteration 0x13 -> index 3 -> 0x303030. ismandelbrot = 1 with iteration 0x13 -> 0x000000.
- Write pal[5] = 0x12AB34, PAL_HI, iteration 0x5C -> index 5 -> 0x12AB34. Write pal[5] on the same edge as that lookup -> old value 0x505050; next pixel -> 0x12AB34.
- Backpressure: stream 4 pixels, out_ready low for 3 cycles mid-stream -> in_ready drops once both stages are full, rgb held stable, all 4 pixels delivered in order exactly once.
- nrst asserted with both stages full -> out_valid = 0 and rgb = 0 after the edge; palette reads as the ramp; nothing emitted from the flushed pixels.
- Parameter sweep ITER_W = 10, CH_W = 6, PAL_DEPTH = 64, GRAY iteration 0x3FF -> each channel 0x3F. PAL_HI iteration 0x3FF -> index 63.
